// File: rtl/unit_hazard_forward.sv
// Data-hazard unit for the 5-stage MIPS pipeline: EX/ID operand forwarding plus load-use and
// branch-dependency stall FSM. Optional stall statistics counter under `HAZARD_STATS_EN`.
module unit_hazard_forward #(
  parameter int unsigned BITS_REGS          = 5,
  parameter int unsigned BITS_CORTOCIRCUITO = 3,
  parameter int unsigned BITS_FWD_BRANCH    = 2,
  parameter int unsigned BITS_STALL_CNT     = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_valid_ID,
  input  logic [BITS_REGS-1:0]          i_ID_rs,
  input  logic [BITS_REGS-1:0]          i_ID_rt,
  input  logic                          i_ID_uses_rt,
  input  logic                          i_ID_is_branch,
  input  logic                          i_flush_ID,
  input  logic                          i_IDEX_reg_write,
  input  logic                          i_IDEX_mem_read,
  input  logic [BITS_REGS-1:0]          i_IDEX_rd,
  input  logic [BITS_REGS-1:0]          i_EX_rs,
  input  logic [BITS_REGS-1:0]          i_EX_rt,
  input  logic                          i_EXMEM_reg_write,
  input  logic                          i_EXMEM_mem_read,
  input  logic [BITS_REGS-1:0]          i_EXMEM_rd,
  input  logic                          i_MEMWB_reg_write,
  input  logic [BITS_REGS-1:0]          i_MEMWB_rd,
  output logic [BITS_CORTOCIRCUITO-1:0] o_mux_A,
  output logic [BITS_CORTOCIRCUITO-1:0] o_mux_B,
  output logic [BITS_FWD_BRANCH-1:0]    o_fwd_branch_A,
  output logic [BITS_FWD_BRANCH-1:0]    o_fwd_branch_B,
  output logic                          o_stall_pc,
  output logic                          o_stall_IFID,
  output logic                          o_flush_IDEX,
  output logic [31:0]                   o_stall_count
);

  localparam logic [BITS_CORTOCIRCUITO-1:0] MuxRf    = '0;
  localparam logic [BITS_CORTOCIRCUITO-1:0] MuxExMem = BITS_CORTOCIRCUITO'(1);
  localparam logic [BITS_CORTOCIRCUITO-1:0] MuxMemWb = BITS_CORTOCIRCUITO'(2);
  localparam logic [BITS_FWD_BRANCH-1:0]    BrRf     = '0;
  localparam logic [BITS_FWD_BRANCH-1:0]    BrExMem  = BITS_FWD_BRANCH'(1);
  localparam logic [BITS_FWD_BRANCH-1:0]    BrMemWb  = BITS_FWD_BRANCH'(2);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e                    state_q, state_d;
  logic [BITS_STALL_CNT-1:0] cnt_q, cnt_d;
  logic [1:0]                stall_k;
  logic                      stall;
  logic                      stall_out;

  // Loads in MEM have no data yet, so EX/MEM is only a forwarding source for ALU results.
  logic exmem_src_ok, memwb_src_ok;
  assign exmem_src_ok = i_EXMEM_reg_write && !i_EXMEM_mem_read && (i_EXMEM_rd != '0);
  assign memwb_src_ok = i_MEMWB_reg_write && (i_MEMWB_rd != '0);

  logic branch_fwd_en;
  assign branch_fwd_en = i_ID_is_branch && i_valid_ID;

  always_comb begin
    o_mux_A        = MuxRf;
    o_mux_B        = MuxRf;
    o_fwd_branch_A = BrRf;
    o_fwd_branch_B = BrRf;
    if (!i_reset) begin
      if (exmem_src_ok && (i_EXMEM_rd == i_EX_rs)) begin
        o_mux_A = MuxExMem;
      end else if (memwb_src_ok && (i_MEMWB_rd == i_EX_rs)) begin
        o_mux_A = MuxMemWb;
      end

      if (exmem_src_ok && (i_EXMEM_rd == i_EX_rt)) begin
        o_mux_B = MuxExMem;
      end else if (memwb_src_ok && (i_MEMWB_rd == i_EX_rt)) begin
        o_mux_B = MuxMemWb;
      end

      if (branch_fwd_en) begin
        if (exmem_src_ok && (i_EXMEM_rd == i_ID_rs)) begin
          o_fwd_branch_A = BrExMem;
        end else if (memwb_src_ok && (i_MEMWB_rd == i_ID_rs)) begin
          o_fwd_branch_A = BrMemWb;
        end

        if (exmem_src_ok && (i_EXMEM_rd == i_ID_rt)) begin
          o_fwd_branch_B = BrExMem;
        end else if (memwb_src_ok && (i_MEMWB_rd == i_ID_rt)) begin
          o_fwd_branch_B = BrMemWb;
        end
      end
    end
  end

  // Dependency hits of the ID sources against the producers in EX and MEM.
  logic idex_rs_hit, idex_rt_hit, exmem_rs_hit, exmem_rt_hit;
  assign idex_rs_hit  = (i_IDEX_rd != '0) && (i_IDEX_rd == i_ID_rs);
  assign idex_rt_hit  = (i_IDEX_rd != '0) && (i_IDEX_rd == i_ID_rt);
  assign exmem_rs_hit = (i_EXMEM_rd != '0) && (i_EXMEM_rd == i_ID_rs);
  assign exmem_rt_hit = (i_EXMEM_rd != '0) && (i_EXMEM_rd == i_ID_rt);

  logic load_use, br_load_ex, br_alu_ex, br_load_mem;
  assign load_use    = i_IDEX_mem_read && (idex_rs_hit || (i_ID_uses_rt && idex_rt_hit));
  assign br_load_ex  = i_ID_is_branch && i_IDEX_mem_read && (idex_rs_hit || idex_rt_hit);
  assign br_alu_ex   = i_ID_is_branch && i_IDEX_reg_write && (idex_rs_hit || idex_rt_hit);
  assign br_load_mem = i_ID_is_branch && i_EXMEM_mem_read && (exmem_rs_hit || exmem_rt_hit);

  // Later assignments override earlier ones, so the largest requirement wins.
  always_comb begin
    stall_k = 2'd0;
    if (i_valid_ID && !i_flush_ID) begin
      if (load_use || br_alu_ex || br_load_mem) begin
        stall_k = 2'd1;
      end
      if (br_load_ex) begin
        stall_k = 2'd2;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (i_flush_ID) begin
      state_d = StRun;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (stall_k != 2'd0) begin
            stall   = 1'b1;
            cnt_d   = BITS_STALL_CNT'(stall_k - 2'd1);
            state_d = (stall_k == 2'd2) ? StStall : StRun;
          end
        end
        StStall: begin
          stall = 1'b1;
          cnt_d = cnt_q - BITS_STALL_CNT'(1);
          if (cnt_d == '0) begin
            state_d = StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_out    = stall && !i_reset;
  assign o_stall_pc   = stall_out;
  assign o_stall_IFID = stall_out;
  assign o_flush_IDEX = stall_out;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_out && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign o_stall_count = stall_count_q;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_unit_hazard_forward.sv
// Scoreboard bench for unit_hazard_forward: directed vectors push expectations, a negedge
// monitor pops and compares. Build with +define+HAZARD_STATS_EN to check the stall counter.
module tb_unit_hazard_forward;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_valid_ID;
  logic [4:0] i_ID_rs, i_ID_rt;
  logic       i_ID_uses_rt, i_ID_is_branch, i_flush_ID;
  logic       i_IDEX_reg_write, i_IDEX_mem_read;
  logic [4:0] i_IDEX_rd, i_EX_rs, i_EX_rt;
  logic       i_EXMEM_reg_write, i_EXMEM_mem_read;
  logic [4:0] i_EXMEM_rd;
  logic       i_MEMWB_reg_write;
  logic [4:0] i_MEMWB_rd;
  logic [2:0] o_mux_A, o_mux_B;
  logic [1:0] o_fwd_branch_A, o_fwd_branch_B;
  logic       o_stall_pc, o_stall_IFID, o_flush_IDEX;
  logic [31:0] o_stall_count;

`ifdef HAZARD_STATS_EN
  localparam logic [31:0] ExpStats = 32'd5;
`else
  localparam logic [31:0] ExpStats = 32'd0;
`endif

  always #5 i_clk = ~i_clk;

  unit_hazard_forward dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_valid_ID        (i_valid_ID),
    .i_ID_rs           (i_ID_rs),
    .i_ID_rt           (i_ID_rt),
    .i_ID_uses_rt      (i_ID_uses_rt),
    .i_ID_is_branch    (i_ID_is_branch),
    .i_flush_ID        (i_flush_ID),
    .i_IDEX_reg_write  (i_IDEX_reg_write),
    .i_IDEX_mem_read   (i_IDEX_mem_read),
    .i_IDEX_rd         (i_IDEX_rd),
    .i_EX_rs           (i_EX_rs),
    .i_EX_rt           (i_EX_rt),
    .i_EXMEM_reg_write (i_EXMEM_reg_write),
    .i_EXMEM_mem_read  (i_EXMEM_mem_read),
    .i_EXMEM_rd        (i_EXMEM_rd),
    .i_MEMWB_reg_write (i_MEMWB_reg_write),
    .i_MEMWB_rd        (i_MEMWB_rd),
    .o_mux_A           (o_mux_A),
    .o_mux_B           (o_mux_B),
    .o_fwd_branch_A    (o_fwd_branch_A),
    .o_fwd_branch_B    (o_fwd_branch_B),
    .o_stall_pc        (o_stall_pc),
    .o_stall_IFID      (o_stall_IFID),
    .o_flush_IDEX      (o_flush_IDEX),
    .o_stall_count     (o_stall_count)
  );

  typedef struct {
    string       name;
    logic [2:0]  ma, mb;
    logic [1:0]  fa, fb;
    logic        st;
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Outputs are combinational on the inputs driven at posedge+1, so negedge sees them settled.
  always @(negedge i_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ({o_mux_A, o_mux_B, o_fwd_branch_A, o_fwd_branch_B} != {e.ma, e.mb, e.fa, e.fb}) begin
        bad++;
        $display("FAIL %s fwd: got A=%b B=%b bA=%b bB=%b want A=%b B=%b bA=%b bB=%b", e.name,
                 o_mux_A, o_mux_B, o_fwd_branch_A, o_fwd_branch_B, e.ma, e.mb, e.fa, e.fb);
      end
      total++;
      if ({o_stall_pc, o_stall_IFID, o_flush_IDEX} != {3{e.st}}) begin
        bad++;
        $display("FAIL %s stall: got pc=%b ifid=%b idex=%b want %b", e.name, o_stall_pc,
                 o_stall_IFID, o_flush_IDEX, e.st);
      end
      if (e.chk_cnt) begin
        total++;
        if (o_stall_count != e.cnt) begin
          bad++;
          $display("FAIL %s count: got %0d want %0d", e.name, o_stall_count, e.cnt);
        end
      end
    end
  end

  task automatic clear();
    i_reset = 0; i_valid_ID = 0; i_ID_rs = 0; i_ID_rt = 0; i_ID_uses_rt = 0;
    i_ID_is_branch = 0; i_flush_ID = 0; i_IDEX_reg_write = 0; i_IDEX_mem_read = 0;
    i_IDEX_rd = 0; i_EX_rs = 0; i_EX_rt = 0; i_EXMEM_reg_write = 0; i_EXMEM_mem_read = 0;
    i_EXMEM_rd = 0; i_MEMWB_reg_write = 0; i_MEMWB_rd = 0;
  endtask

  task automatic step(input string nm, input logic [2:0] ma, input logic [2:0] mb,
                      input logic [1:0] fa, input logic [1:0] fb, input logic st,
                      input bit chk = 0, input logic [31:0] cnt = 0);
    exp_t e;
    e.name = nm; e.ma = ma; e.mb = mb; e.fa = fa; e.fb = fb; e.st = st;
    e.chk_cnt = chk; e.cnt = cnt;
    q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic lw_in_ex(input logic [4:0] rd);
    i_IDEX_mem_read = 1; i_IDEX_reg_write = 1; i_IDEX_rd = rd;
  endtask

  initial begin
    clear();
    @(posedge i_clk);
    #1;
    // Reset with matching producers: everything forced to zero.
    i_reset = 1; i_valid_ID = 1; i_ID_rs = 5; i_EX_rs = 5; i_EXMEM_reg_write = 1;
    i_EXMEM_rd = 5; lw_in_ex(5);
    step("reset_outputs", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    step("reset_count", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1, 0);

    // Load-use: one stall, FSM stays in RUN.
    clear(); i_valid_ID = 1; i_ID_rs = 2; lw_in_ex(2);
    step("loaduse_stall", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    clear(); i_valid_ID = 1; i_ID_rs = 2; i_EX_rs = 2;
    i_EXMEM_reg_write = 1; i_EXMEM_mem_read = 1; i_EXMEM_rd = 2;
    step("loaduse_release_noload_fwd", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    clear(); i_EX_rs = 2; i_MEMWB_reg_write = 1; i_MEMWB_rd = 2;
    step("loaduse_memwb_fwd", 3'b010, 3'b000, 2'b00, 2'b00, 1'b0);

    // Branch on load in EX: two stalls, STALL ignores valid and inputs.
    clear(); i_valid_ID = 1; i_ID_is_branch = 1; i_ID_rs = 3; i_ID_rt = 7; lw_in_ex(3);
    step("br_load_stall1", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    clear(); i_ID_is_branch = 1; i_ID_rs = 3; i_ID_rt = 7;
    i_EXMEM_reg_write = 1; i_EXMEM_mem_read = 1; i_EXMEM_rd = 3;
    step("br_load_stall2", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    clear(); i_valid_ID = 1; i_ID_is_branch = 1; i_ID_rs = 3; i_ID_rt = 7;
    i_MEMWB_reg_write = 1; i_MEMWB_rd = 3;
    step("br_load_release_fwd", 3'b000, 3'b000, 2'b10, 2'b00, 1'b0);

    // Priority and $0 exclusion.
    clear(); i_EX_rs = 4; i_EX_rt = 4; i_EXMEM_reg_write = 1; i_EXMEM_rd = 4;
    i_MEMWB_reg_write = 1; i_MEMWB_rd = 4;
    step("exmem_priority", 3'b001, 3'b001, 2'b00, 2'b00, 1'b0);
    clear(); i_EXMEM_reg_write = 1; i_MEMWB_reg_write = 1; i_valid_ID = 1;
    i_ID_is_branch = 1; i_IDEX_mem_read = 1; i_IDEX_reg_write = 1;
    step("reg0_excluded", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Branch forwarding from EX/MEM, gated by valid.
    clear(); i_valid_ID = 1; i_ID_is_branch = 1; i_ID_rt = 6; i_EXMEM_reg_write = 1;
    i_EXMEM_rd = 6;
    step("br_fwd_exmem", 3'b000, 3'b000, 2'b00, 2'b01, 1'b0);
    i_valid_ID = 0;
    step("br_fwd_invalid", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Branch on ALU op in EX: one stall only.
    clear(); i_valid_ID = 1; i_ID_is_branch = 1; i_ID_rs = 8; i_IDEX_reg_write = 1;
    i_IDEX_rd = 8;
    step("br_alu_stall", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    clear();
    step("br_alu_release", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);

    // rt matters for load-use only when the instruction reads it.
    clear(); i_valid_ID = 1; i_ID_rt = 9; lw_in_ex(9);
    step("rt_unused", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    i_ID_uses_rt = 1;
    step("rt_used", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);

    // Flush in the second branch-stall cycle.
    clear(); i_valid_ID = 1; i_ID_is_branch = 1; i_ID_rs = 3; lw_in_ex(3);
    step("flush_pre", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    clear(); i_flush_ID = 1;
    step("flush_cycle", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    clear();
    step("flush_after_run", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    clear(); i_valid_ID = 1; i_flush_ID = 1; i_ID_rs = 2; lw_in_ex(2);
    step("flush_beats_hazard", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Reset in the second branch-stall cycle.
    clear(); i_valid_ID = 1; i_ID_is_branch = 1; i_ID_rs = 3; lw_in_ex(3);
    step("rst_pre", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    clear(); i_reset = 1; i_EX_rs = 4; i_EXMEM_reg_write = 1; i_EXMEM_rd = 4;
    step("rst_cycle", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    clear();
    step("rst_after_run", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Hazard on an invalid ID slot.
    clear(); i_ID_rs = 2; lw_in_ex(2);
    step("invalid_no_stall", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);

    // Statistics: three load-use stalls plus one two-cycle branch stall.
    clear(); i_reset = 1;
    step("stats_reset", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clear(); i_valid_ID = 1; i_ID_rs = 2; lw_in_ex(2);
      step("stats_lu", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
      clear();
      step("stats_gap", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
    end
    clear(); i_valid_ID = 1; i_ID_is_branch = 1; i_ID_rt = 3; lw_in_ex(3);
    step("stats_br1", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    clear();
    step("stats_br2", 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
    step("stats_total", 3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1, ExpStats);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge i_clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
